// File: rtl/exe_mem_skid_reg.sv
// EXE->MEM pipeline register with valid/ready handshake and a two-entry skid buffer.
// Optional feature: define STALL_CNT_EN to add a saturating 16-bit upstream stall counter.
module exe_mem_skid_reg #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned PC_W   = 32,
    parameter int unsigned DEST_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_wb_en,
    input  logic              in_mem_r_en,
    input  logic              in_mem_w_en,
    input  logic [PC_W-1:0]   in_pc,
    input  logic [DATA_W-1:0] in_alu_result,
    input  logic [DATA_W-1:0] in_st_val,
    input  logic [DEST_W-1:0] in_dest,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_wb_en,
    output logic              out_mem_r_en,
    output logic              out_mem_w_en,
    output logic [PC_W-1:0]   out_pc,
    output logic [DATA_W-1:0] out_alu_result,
    output logic [DATA_W-1:0] out_st_val,
    output logic [DEST_W-1:0] out_dest
`ifdef STALL_CNT_EN
    ,
    output logic [15:0]       stall_cnt
`endif
);

    // Main entry (drives outputs)
    logic              m_valid_q, m_valid_d;
    logic              m_wb_q, m_wb_d, m_mr_q, m_mr_d, m_mw_q, m_mw_d;
    logic [PC_W-1:0]   m_pc_q, m_pc_d;
    logic [DATA_W-1:0] m_alu_q, m_alu_d, m_st_q, m_st_d;
    logic [DEST_W-1:0] m_dest_q, m_dest_d;

    // Skid entry
    logic              s_valid_q, s_valid_d;
    logic              s_wb_q, s_wb_d, s_mr_q, s_mr_d, s_mw_q, s_mw_d;
    logic [PC_W-1:0]   s_pc_q, s_pc_d;
    logic [DATA_W-1:0] s_alu_q, s_alu_d, s_st_q, s_st_d;
    logic [DEST_W-1:0] s_dest_q, s_dest_d;

    // Registered copy of !s_valid so in_ready never depends on out_ready combinationally.
    logic in_ready_q, in_ready_d;

    logic accept;
    logic advance;

    assign accept  = in_valid && in_ready_q;
    assign advance = !m_valid_q || out_ready;

    always_comb begin
        m_valid_d = m_valid_q;
        m_wb_d    = m_wb_q;
        m_mr_d    = m_mr_q;
        m_mw_d    = m_mw_q;
        m_pc_d    = m_pc_q;
        m_alu_d   = m_alu_q;
        m_st_d    = m_st_q;
        m_dest_d  = m_dest_q;
        s_valid_d = s_valid_q;
        s_wb_d    = s_wb_q;
        s_mr_d    = s_mr_q;
        s_mw_d    = s_mw_q;
        s_pc_d    = s_pc_q;
        s_alu_d   = s_alu_q;
        s_st_d    = s_st_q;
        s_dest_d  = s_dest_q;

        if (flush) begin
            m_valid_d = 1'b0;
            s_valid_d = 1'b0;
            m_wb_d    = 1'b0;
            m_mr_d    = 1'b0;
            m_mw_d    = 1'b0;
        end else if (advance) begin
            if (s_valid_q) begin
                m_valid_d = 1'b1;
                m_wb_d    = s_wb_q;
                m_mr_d    = s_mr_q;
                m_mw_d    = s_mw_q;
                m_pc_d    = s_pc_q;
                m_alu_d   = s_alu_q;
                m_st_d    = s_st_q;
                m_dest_d  = s_dest_q;
                s_valid_d = accept;
                if (accept) begin
                    s_wb_d   = in_wb_en;
                    s_mr_d   = in_mem_r_en;
                    s_mw_d   = in_mem_w_en;
                    s_pc_d   = in_pc;
                    s_alu_d  = in_alu_result;
                    s_st_d   = in_st_val;
                    s_dest_d = in_dest;
                end
            end else if (accept) begin
                m_valid_d = 1'b1;
                m_wb_d    = in_wb_en;
                m_mr_d    = in_mem_r_en;
                m_mw_d    = in_mem_w_en;
                m_pc_d    = in_pc;
                m_alu_d   = in_alu_result;
                m_st_d    = in_st_val;
                m_dest_d  = in_dest;
            end else begin
                // Clear control bits so consumers ignoring out_valid never write.
                m_valid_d = 1'b0;
                m_wb_d    = 1'b0;
                m_mr_d    = 1'b0;
                m_mw_d    = 1'b0;
            end
        end else if (accept) begin
            s_valid_d = 1'b1;
            s_wb_d    = in_wb_en;
            s_mr_d    = in_mem_r_en;
            s_mw_d    = in_mem_w_en;
            s_pc_d    = in_pc;
            s_alu_d   = in_alu_result;
            s_st_d    = in_st_val;
            s_dest_d  = in_dest;
        end

        in_ready_d = !s_valid_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_valid_q  <= 1'b0;
            m_wb_q     <= 1'b0;
            m_mr_q     <= 1'b0;
            m_mw_q     <= 1'b0;
            m_pc_q     <= '0;
            m_alu_q    <= '0;
            m_st_q     <= '0;
            m_dest_q   <= '0;
            s_valid_q  <= 1'b0;
            s_wb_q     <= 1'b0;
            s_mr_q     <= 1'b0;
            s_mw_q     <= 1'b0;
            s_pc_q     <= '0;
            s_alu_q    <= '0;
            s_st_q     <= '0;
            s_dest_q   <= '0;
            in_ready_q <= 1'b1;
        end else begin
            m_valid_q  <= m_valid_d;
            m_wb_q     <= m_wb_d;
            m_mr_q     <= m_mr_d;
            m_mw_q     <= m_mw_d;
            m_pc_q     <= m_pc_d;
            m_alu_q    <= m_alu_d;
            m_st_q     <= m_st_d;
            m_dest_q   <= m_dest_d;
            s_valid_q  <= s_valid_d;
            s_wb_q     <= s_wb_d;
            s_mr_q     <= s_mr_d;
            s_mw_q     <= s_mw_d;
            s_pc_q     <= s_pc_d;
            s_alu_q    <= s_alu_d;
            s_st_q     <= s_st_d;
            s_dest_q   <= s_dest_d;
            in_ready_q <= in_ready_d;
        end
    end

    assign in_ready       = in_ready_q;
    assign out_valid      = m_valid_q;
    assign out_wb_en      = m_wb_q;
    assign out_mem_r_en   = m_mr_q;
    assign out_mem_w_en   = m_mw_q;
    assign out_pc         = m_pc_q;
    assign out_alu_result = m_alu_q;
    assign out_st_val     = m_st_q;
    assign out_dest       = m_dest_q;

`ifdef STALL_CNT_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (in_valid && !in_ready_q && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= 16'd0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_exe_mem_skid_reg.sv
// Directed self-checking bench for exe_mem_skid_reg; stall counter checks run when
// STALL_CNT_EN is defined.
module tb_exe_mem_skid_reg;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic        in_wb_en, in_mem_r_en, in_mem_w_en;
    logic [31:0] in_pc, in_alu_result, in_st_val;
    logic [3:0]  in_dest;
    logic        out_valid;
    logic        out_ready;
    logic        out_wb_en, out_mem_r_en, out_mem_w_en;
    logic [31:0] out_pc, out_alu_result, out_st_val;
    logic [3:0]  out_dest;
`ifdef STALL_CNT_EN
    logic [15:0] stall_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    exe_mem_skid_reg dut (
        .clk            (clk),
        .rst            (rst),
        .flush          (flush),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_wb_en       (in_wb_en),
        .in_mem_r_en    (in_mem_r_en),
        .in_mem_w_en    (in_mem_w_en),
        .in_pc          (in_pc),
        .in_alu_result  (in_alu_result),
        .in_st_val      (in_st_val),
        .in_dest        (in_dest),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_wb_en      (out_wb_en),
        .out_mem_r_en   (out_mem_r_en),
        .out_mem_w_en   (out_mem_w_en),
        .out_pc         (out_pc),
        .out_alu_result (out_alu_result),
        .out_st_val     (out_st_val),
        .out_dest       (out_dest)
`ifdef STALL_CNT_EN
        ,
        .stall_cnt      (stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] alu, input logic [3:0] dest,
                         input logic wb, input logic mr, input logic mw);
        in_valid      = v;
        in_alu_result = alu;
        in_dest       = dest;
        in_wb_en      = wb;
        in_mem_r_en   = mr;
        in_mem_w_en   = mw;
        in_pc         = 32'h1000 + alu;
        in_st_val     = ~alu;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        flush = 1'b0;
        out_ready = 1'b0;
        drive(1'b0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0);
        #12;
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_alu_result !== 32'h0 ||
            out_pc !== 32'h0 || out_wb_en !== 1'b0 || out_dest !== 4'h0) begin
            n_fail++;
            $display("FAIL reset_state: valid=%b ready=%b alu=%h pc=%h wb=%b dest=%h, want 0 1 0 0 0 0",
                     out_valid, in_ready, out_alu_result, out_pc, out_wb_en, out_dest);
        end
        @(negedge clk);
        rst = 1'b0;
        tick();
    endtask

    task automatic test_streaming();
        logic [31:0] alu;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            alu = 32'h11 * (i + 1);
            drive(1'b1, alu, 4'(i + 1), 1'b1, i[0], ~i[0]);
            tick();
            n_checks++;
            if (out_valid !== 1'b1 || out_alu_result !== alu || out_dest !== 4'(i + 1) ||
                out_pc !== 32'h1000 + alu || out_st_val !== ~alu || out_wb_en !== 1'b1 ||
                out_mem_r_en !== i[0] || out_mem_w_en !== ~i[0] || in_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL stream_%0d: valid=%b alu=%h dest=%h pc=%h st=%h wb=%b mr=%b mw=%b rdy=%b, want alu=%h dest=%0d",
                         i, out_valid, out_alu_result, out_dest, out_pc, out_st_val,
                         out_wb_en, out_mem_r_en, out_mem_w_en, in_ready, alu, i + 1);
            end
        end
        drive(1'b0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0);
        tick();
        n_checks++;
        if (out_valid !== 1'b0 || out_wb_en !== 1'b0 || out_mem_w_en !== 1'b0 ||
            out_mem_r_en !== 1'b0 || out_alu_result !== 32'h44) begin
            n_fail++;
            $display("FAIL stream_drain: valid=%b wb=%b mr=%b mw=%b alu=%h, want 0 0 0 0 44",
                     out_valid, out_wb_en, out_mem_r_en, out_mem_w_en, out_alu_result);
        end
    endtask

    // Leaves M=A (0xA0) and S=B (0xB0) held with out_ready=0.
    task automatic fill_two();
        out_ready = 1'b0;
        drive(1'b1, 32'hA0, 4'hA, 1'b1, 1'b0, 1'b1);
        tick();
        drive(1'b1, 32'hB0, 4'hB, 1'b1, 1'b1, 1'b0);
        tick();
    endtask

    task automatic test_back_pressure();
        logic [31:0] exp_alu [3];
        exp_alu[0] = 32'hA0;
        exp_alu[1] = 32'hB0;
        exp_alu[2] = 32'hC0;
        out_ready = 1'b0;
        drive(1'b1, 32'hA0, 4'hA, 1'b1, 1'b0, 1'b1);
        tick();
        n_checks++;
        if (out_valid !== 1'b1 || out_alu_result !== 32'hA0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_first: valid=%b alu=%h rdy=%b, want 1 a0 1",
                     out_valid, out_alu_result, in_ready);
        end
        drive(1'b1, 32'hB0, 4'hB, 1'b1, 1'b1, 1'b0);
        tick();
        n_checks++;
        if (out_alu_result !== 32'hA0 || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_skid_full: alu=%h rdy=%b, want a0 0", out_alu_result, in_ready);
        end
        drive(1'b1, 32'hC0, 4'hC, 1'b0, 1'b0, 1'b0);
        tick();
        n_checks++;
        if (out_valid !== 1'b1 || out_alu_result !== 32'hA0 || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_hold: valid=%b alu=%h rdy=%b, want 1 a0 0",
                     out_valid, out_alu_result, in_ready);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (out_valid !== 1'b1 || out_alu_result !== exp_alu[i]) begin
                n_fail++;
                $display("FAIL bp_drain_%0d: valid=%b alu=%h, want 1 %h",
                         i, out_valid, out_alu_result, exp_alu[i]);
            end
            tick();
            if (i == 0) begin
                n_checks++;
                if (in_ready !== 1'b1) begin
                    n_fail++;
                    $display("FAIL bp_ready_back: rdy=%b, want 1", in_ready);
                end
            end
            if (i == 1) drive(1'b0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0);
        end
        n_checks++;
        if (out_valid !== 1'b0 || out_wb_en !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_empty: valid=%b wb=%b, want 0 0", out_valid, out_wb_en);
        end
    endtask

    task automatic test_flush();
        fill_two();
        drive(1'b1, 32'hD0, 4'hD, 1'b1, 1'b0, 1'b1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        n_checks++;
        if (out_valid !== 1'b0 || out_mem_w_en !== 1'b0 || out_wb_en !== 1'b0 ||
            in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_state: valid=%b mw=%b wb=%b rdy=%b, want 0 0 0 1",
                     out_valid, out_mem_w_en, out_wb_en, in_ready);
        end
        drive(1'b0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0);
        out_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            n_checks++;
            if (out_valid !== 1'b0 || out_alu_result === 32'hD0) begin
                n_fail++;
                $display("FAIL flush_no_d_%0d: valid=%b alu=%h, want valid 0, never d0",
                         i, out_valid, out_alu_result);
            end
        end
    endtask

    task automatic test_flush_fire();
        out_ready = 1'b1;
        drive(1'b1, 32'hE0, 4'hE, 1'b1, 1'b1, 1'b0);
        tick();
        drive(1'b0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0);
        flush = 1'b1;
        n_checks++;
        if (out_valid !== 1'b1 || out_alu_result !== 32'hE0 || out_dest !== 4'hE) begin
            n_fail++;
            $display("FAIL flush_fire_seen: valid=%b alu=%h dest=%h, want 1 e0 e",
                     out_valid, out_alu_result, out_dest);
        end
        tick();
        flush = 1'b0;
        n_checks++;
        if (out_valid !== 1'b0 || out_mem_r_en !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_fire_after: valid=%b mr=%b rdy=%b, want 0 0 1",
                     out_valid, out_mem_r_en, in_ready);
        end
    endtask

    task automatic test_reset_mid();
        fill_two();
        @(negedge clk);
        rst = 1'b1;
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_alu_result !== 32'h0 ||
            out_wb_en !== 1'b0 || out_mem_w_en !== 1'b0 || out_st_val !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_mid: valid=%b rdy=%b alu=%h wb=%b mw=%b st=%h, want 0 1 0 0 0 0",
                     out_valid, in_ready, out_alu_result, out_wb_en, out_mem_w_en, out_st_val);
        end
        drive(1'b0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        tick();
    endtask

`ifdef STALL_CNT_EN
    task automatic test_stall_cnt();
        n_checks++;
        if (stall_cnt !== 16'd0) begin
            n_fail++;
            $display("FAIL stall_reset: cnt=%0d, want 0", stall_cnt);
        end
        out_ready = 1'b0;
        drive(1'b1, 32'h55, 4'h5, 1'b1, 1'b0, 1'b0);
        repeat (10) tick();
        n_checks++;
        if (stall_cnt !== 16'd8) begin
            n_fail++;
            $display("FAIL stall_10: cnt=%0d, want 8", stall_cnt);
        end
        repeat (70000) tick();
        n_checks++;
        if (stall_cnt !== 16'hFFFF) begin
            n_fail++;
            $display("FAIL stall_sat: cnt=%h, want ffff", stall_cnt);
        end
        flush = 1'b1;
        tick();
        flush = 1'b0;
        n_checks++;
        if (stall_cnt !== 16'hFFFF) begin
            n_fail++;
            $display("FAIL stall_flush: cnt=%h, want ffff", stall_cnt);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_streaming();
        test_back_pressure();
        test_flush();
        test_flush_fire();
        test_reset_mid();
`ifdef STALL_CNT_EN
        test_stall_cnt();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/exe_mem_skid_reg.md
# exe_mem_skid_reg

Parametrised EXE→MEM pipeline register with a valid/ready handshake and a two-entry skid buffer. It carries the execute-stage result bundle (WB/MEM control bits, PC, ALU result, store value, destination register) into the memory stage. It supports downstream back-pressure without a combinational ready path, and a synchronous flush for branch redirect. Latency is 1 cycle; throughput is 1 bundle per cycle.

## Interface
- DATA_W, default 32: width of ALU result and store value.
- PC_W, default 32: width of PC.
- DEST_W, default 4: width of destination register index.

- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- flush  in  1  synchronous flush; discards all held and incoming bundles.
- in_valid  in  1  upstream bundle valid.
- in_ready  out  1  block can accept a bundle this cycle.
- in_wb_en, in_mem_r_en, in_mem_w_en  in  1 each  control bits.
- in_pc  in  PC_W  PC of the instruction.
- in_alu_result  in  DATA_W  ALU result / memory address.
- in_st_val  in  DATA_W  store data.
- in_dest  in  DEST_W  writeback register index.
- out_valid  out  1  output bundle valid.
- out_ready  in  1  downstream accepts the bundle.
- out_wb_en, out_mem_r_en, out_mem_w_en, out_pc, out_alu_result, out_st_val, out_dest  out  same widths as inputs  registered bundle.
- stall_cnt  out  16  present only with STALL_CNT_EN.

## Operation
- Two entries: main M (drives outputs) and skid S. Each entry holds a valid bit and the full bundle.
- in_ready = !S.valid, driven directly from a flop. There is no combinational path from out_ready to in_ready.
- Accept = in_valid && in_ready. Fire = out_valid && out_ready. out_valid = M.valid.
- Per rising edge, in priority order:
  - flush: M.valid←0, S.valid←0, M control bits←0. The input in this cycle is dropped even if in_ready=1.
  - M empty or Fire:
    - If S.valid: M←S, S.valid←0, and an accepted input goes to S.
    - Otherwise, if Accept: M←input.
    - Otherwise: M.valid←0.
  - M held (valid && !out_ready): an accepted input goes to S.
- Whenever M becomes invalid, out_wb_en, out_mem_r_en and out_mem_w_en are cleared to 0. Downstream logic that ignores out_valid therefore never writes. Data fields keep their last value.
- Ordering is strict FIFO. No bundle is lost or duplicated.

## Timing
- Reset (asynchronous, immediate): all outputs 0, out_valid=0, in_ready=1, both entries invalid, stall_cnt=0.
- Latency: a bundle accepted at edge n is on the outputs after edge n, with out_valid=1.
- With out_ready held at 1, back-to-back bundles stream at 1 per cycle and out_valid stays high.
- After out_ready drops, at most one further bundle is accepted (into S). in_ready goes low the cycle after S fills.
- When out_ready rises with both entries full: S moves to M on that edge and in_ready returns to 1 after it.
- Flush together with Fire in the same cycle: the downstream transfer counts; both entries are empty after the edge.
- Reset mid-transfer: the state is lost immediately; upstream must re-send.

## Configuration
- STALL_CNT_EN defined:
  - Adds the stall_cnt output and a 16-bit counter.
  - The counter increments on each edge where in_valid && !in_ready, and saturates at 0xFFFF.
  - It is cleared only by rst; flush does not clear it.
- STALL_CNT_EN undefined: the port and the counter are absent, and the remaining behaviour is identical.

## Test plan
- Reset: assert rst mid-simulation with no clock edge → all outputs 0 and in_ready=1 immediately.
- Streaming: out_ready=1; send alu_result 0x11, 0x22, 0x33, 0x44 on consecutive cycles with dest 1..4 → each appears 1 cycle later; out_valid high for 4 cycles, then low with out_wb_en=0.
- Back-pressure: out_ready=0; send A (0xA0) and B (0xB0). Expected: in_ready=0 from the cycle after B; upstream holds C (0xC0). Then set out_ready=1 → outputs A, B, C on consecutive cycles, no duplicates.
- Flush: with M=A and S=B both valid, and in_valid=1 with D, assert flush for 1 cycle → next cycle out_valid=0, out_mem_w_en=0, in_ready=1; D is never output.
- Flush with Fire: out_ready=1, M valid, flush=1 → the downstream sees M for that cycle; after the edge out_valid=0.
- STALL_CNT_EN: in_valid=1 and out_ready=0 for 10 cycles from empty → stall_cnt=8. Then 70000 further stall cycles → stall_cnt=0xFFFF. Then flush → stall_cnt unchanged.
